sram_port_arbiter: RTL

Two-requester arbiter and sequencer for the 256×8 single-port synchronous SRAM. It accepts read and write commands from two independent requesters over valid/ready handshakes and issues at most one command per cycle to the SRAM port. It returns read data to the requester that issued the read, in order, with fixed latency. It sits between the SRAM macro and its clients (host interface and test/scrub engine).

---
 rtl/sram_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter and 3-stage sequencer for a 256x8 single-port synchronous SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic gnt0, gnt1, accept;

`ifdef SRAM_ARB_RR_EN
  // last = requester that won most recently; the other one wins a tie.
  logic last;

  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last);
    gnt1 = req1_valid & (~req0_valid | ~last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt0) begin
      last <= 1'b0;
    end else if (gnt1) begin
      last <= 1'b1;
    end
  end
`else
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;

  // Stage C: command register driving the SRAM port
  logic              cmd_v;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_v     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_id    <= 1'b0;
    end else begin
      cmd_v  <= accept;
      cmd_we <= accept & (gnt1 ? req1_we : req0_we);
      if (accept) begin
        cmd_addr  <= gnt1 ? req1_addr : req0_addr;
        cmd_wdata <= gnt1 ? req1_wdata : req0_wdata;
        cmd_id    <= gnt1;
      end
    end
  end

  assign mem_enable = cmd_v;
  assign mem_we     = cmd_v & cmd_we;
  assign mem_addr   = cmd_addr;
  assign mem_wdata  = cmd_wdata;

  // Stage R: aligns the read tag with the SRAM's registered read data
  logic rd_v;
  logic rd_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v  <= 1'b0;
      rd_id <= 1'b0;
    end else begin
      rd_v  <= cmd_v & ~cmd_we;
      rd_id <= cmd_id;
    end
  end

  // Stage O: response registers; rdata holds until the next response to that requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= rd_v & ~rd_id;
      rsp1_valid <= rd_v & rd_id;
      if (rd_v & ~rd_id) begin
        rsp0_rdata <= mem_rdata;
      end
      if (rd_v & rd_id) begin
        rsp1_rdata <= mem_rdata;
      end
    end
  end

  assign busy = cmd_v | rd_v | rsp0_valid | rsp1_valid;

endmodule
